// File: rtl/pc_pkg.sv
// pc_pkg: shared types and helpers for the fetch-PC generator.
//   redirect_kind_e : redirect source; the numeric value is its priority
//                     (NONE lowest, EXC highest), so kinds compare directly.
//   outranks(a, b)  : 1 when kind a has strictly higher priority than kind b.
//   ALIGN_BITS      : target low bits cleared for the default 4-byte instruction.
package pc_pkg;

    typedef enum logic [1:0] {
        KIND_NONE = 2'd0,
        KIND_BR   = 2'd1,
        KIND_ERET = 2'd2,
        KIND_EXC  = 2'd3
    } redirect_kind_e;

    localparam int DEF_INSTR_BYTES = 4;
    localparam int ALIGN_BITS      = $clog2(DEF_INSTR_BYTES);

    // NONE never outranks anything, so "no request" can never win.
    function automatic logic outranks(input redirect_kind_e a, input redirect_kind_e b);
        return (a > b);
    endfunction

endpackage

// File: rtl/pc_pending_slot.sv
// pc_pending_slot: one-entry store for a redirect raised while fetch is stalled.
// Ports:
//   clk, rst     : clock and synchronous active-high reset (empties the slot)
//   capture_i    : load {kind_i, target_i}; the caller only asserts this when
//                  the new kind outranks the stored one
//   consume_i    : empty the slot (the stored or an outranking redirect was applied)
//   kind_i       : kind of the redirect being captured
//   target_i     : aligned target of the redirect being captured
//   kind_o       : stored kind (KIND_NONE when empty)
//   target_o     : stored target
//   occupied_o   : slot holds a redirect
module pc_pending_slot
    import pc_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                capture_i,
    input  logic                consume_i,
    input  redirect_kind_e      kind_i,
    input  logic [ADDR_W-1:0]   target_i,
    output redirect_kind_e      kind_o,
    output logic [ADDR_W-1:0]   target_o,
    output logic                occupied_o
);

    redirect_kind_e    kind_q,   kind_d;
    logic [ADDR_W-1:0] target_q, target_d;

    always_comb begin
        kind_d   = kind_q;
        target_d = target_q;
        if (capture_i) begin
            kind_d   = kind_i;
            target_d = target_i;
        end else if (consume_i) begin
            kind_d   = KIND_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            kind_q   <= KIND_NONE;
            target_q <= '0;
        end else begin
            kind_q   <= kind_d;
            target_q <= target_d;
        end
    end

    assign kind_o     = kind_q;
    assign target_o   = target_q;
    assign occupied_o = (kind_q != KIND_NONE);

endmodule

// File: rtl/pc_gen_unit.sv
// pc_gen_unit: fetch-PC generator with prioritised redirects, stall-time
// redirect capture and a wrapping redirect epoch.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   ena                   : global enable; 0 freezes all state and drops requests
//   stall                 : fetch stall; PC holds, redirects go to the pending slot
//   exc_req               : redirect to EXC_VEC (highest priority)
//   eret_req, eret_target : redirect to the exception return address
//   br_req, br_target     : branch/jump redirect (lowest redirect priority)
//   pc_out                : current fetch PC
//   pc_valid              : pc_out is a real fetch this cycle
//   epoch                 : increments on every accepted redirect
//   redirect              : pulse, a redirect was accepted on the last edge
//   pending               : pending slot occupied
//   addr_err              : pulse, the accepted target had nonzero low bits
module pc_gen_unit
    import pc_pkg::*;
#(
    parameter int              ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = 32'h00400000,
    parameter logic [ADDR_W-1:0] EXC_VEC   = 32'h00400004,
    parameter int              INSTR_BYTES = 4,
    parameter int              EPOCH_W     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                stall,
    input  logic                exc_req,
    input  logic                eret_req,
    input  logic [ADDR_W-1:0]   eret_target,
    input  logic                br_req,
    input  logic [ADDR_W-1:0]   br_target,
    output logic [ADDR_W-1:0]   pc_out,
    output logic                pc_valid,
    output logic [EPOCH_W-1:0]  epoch,
    output logic                redirect,
    output logic                pending,
    output logic                addr_err
);

    // Mask form works for INSTR_BYTES == 1 too (mask becomes zero).
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INSTR_BYTES - 1);
    localparam logic [ADDR_W-1:0] PC_INC   = ADDR_W'(INSTR_BYTES);

    logic [ADDR_W-1:0]  pc_q,    pc_d;
    logic               valid_q, valid_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic               redir_q, redir_d;
    logic               aerr_q,  aerr_d;

    redirect_kind_e     req_kind;
    logic [ADDR_W-1:0]  req_raw;
    logic [ADDR_W-1:0]  req_tgt;
    logic               req_misal;

    redirect_kind_e     slot_kind;
    logic [ADDR_W-1:0]  slot_tgt;
    logic               slot_occ;

    logic               accept;
    logic               capture;
    logic               consume;

    always_comb begin
        req_kind = KIND_NONE;
        req_raw  = '0;
        if (exc_req) begin
            req_kind = KIND_EXC;
            req_raw  = EXC_VEC;
        end else if (eret_req) begin
            req_kind = KIND_ERET;
            req_raw  = eret_target;
        end else if (br_req) begin
            req_kind = KIND_BR;
            req_raw  = br_target;
        end
    end

    assign req_tgt   = req_raw & ~LOW_MASK;
    assign req_misal = |(req_raw & LOW_MASK);

    // An empty slot reads as KIND_NONE, so "any request when empty" and
    // "strictly outranks the stored kind" are the same test.
    assign accept  = ena && outranks(req_kind, slot_kind);
    assign capture = accept && stall;
    assign consume = ena && !stall && slot_occ;

    pc_pending_slot #(
        .ADDR_W (ADDR_W)
    ) u_slot (
        .clk        (clk),
        .rst        (rst),
        .capture_i  (capture),
        .consume_i  (consume),
        .kind_i     (req_kind),
        .target_i   (req_tgt),
        .kind_o     (slot_kind),
        .target_o   (slot_tgt),
        .occupied_o (slot_occ)
    );

    always_comb begin
        pc_d    = pc_q;
        valid_d = valid_q;
        epoch_d = epoch_q;
        redir_d = 1'b0;
        aerr_d  = 1'b0;
        if (ena) begin
            valid_d = !stall;
            epoch_d = epoch_q + EPOCH_W'(accept);
            redir_d = accept;
            aerr_d  = accept && req_misal;
            if (!stall) begin
                if (accept)        pc_d = req_tgt;
                else if (slot_occ) pc_d = slot_tgt;   // already counted at capture
                else               pc_d = pc_q + PC_INC;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_VEC;
            valid_q <= 1'b0;
            epoch_q <= '0;
            redir_q <= 1'b0;
            aerr_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
            epoch_q <= epoch_d;
            redir_q <= redir_d;
            aerr_q  <= aerr_d;
        end
    end

    assign pc_out   = pc_q;
    assign pc_valid = valid_q;
    assign epoch    = epoch_q;
    assign redirect = redir_q;
    assign pending  = slot_occ;
    assign addr_err = aerr_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Scoreboard bench for pc_gen_unit: each stimulus cycle pushes the expected
// post-edge outputs; a monitor pops and compares one entry after every edge.
module tb_pc_gen_unit;

    logic        clk = 1'b0;
    logic        rst, ena, stall, exc_req, eret_req, br_req;
    logic [31:0] eret_target, br_target;
    logic [31:0] pc_out;
    logic        pc_valid, redirect, pending, addr_err;
    logic [1:0]  epoch;

    int total = 0;
    int bad   = 0;

    logic [37:0] exp_q[$];
    string       name_q[$];

    always #5 clk = ~clk;

    pc_gen_unit dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .stall       (stall),
        .exc_req     (exc_req),
        .eret_req    (eret_req),
        .eret_target (eret_target),
        .br_req      (br_req),
        .br_target   (br_target),
        .pc_out      (pc_out),
        .pc_valid    (pc_valid),
        .epoch       (epoch),
        .redirect    (redirect),
        .pending     (pending),
        .addr_err    (addr_err)
    );

    // Monitor: the DUT presents a new output after every rising edge.
    initial begin
        logic [37:0] e, a;
        string       n;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                a = {pc_out, pc_valid, epoch, redirect, pending, addr_err};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL %s: got pc=%h v=%b ep=%0d rd=%b pd=%b ae=%b want pc=%h v=%b ep=%0d rd=%b pd=%b ae=%b",
                             n, a[37:6], a[5], a[4:3], a[2], a[1], a[0],
                             e[37:6], e[5], e[4:3], e[2], e[1], e[0]);
                end
            end
        end
    end

    // Drive one cycle of inputs and push the outputs expected after its edge.
    task automatic step(input logic r, input logic en, input logic st,
                        input logic ex, input logic er, input logic [31:0] er_t,
                        input logic br, input logic [31:0] br_t,
                        input logic [31:0] x_pc, input logic x_v, input logic [1:0] x_ep,
                        input logic x_rd, input logic x_pd, input logic x_ae,
                        input string name);
        @(negedge clk);
        rst = r; ena = en; stall = st;
        exc_req = ex; eret_req = er; eret_target = er_t;
        br_req = br; br_target = br_t;
        exp_q.push_back({x_pc, x_v, x_ep, x_rd, x_pd, x_ae});
        name_q.push_back(name);
    endtask

    task automatic idle(input logic [31:0] x_pc, input logic [1:0] x_ep, input string name);
        step(0, 1, 0, 0, 0, 0, 0, 0, x_pc, 1, x_ep, 0, 0, 0, name);
    endtask

    initial begin
        rst = 1; ena = 1; stall = 0; exc_req = 0; eret_req = 0; br_req = 0;
        eret_target = '0; br_target = '0;

        // Reset (second one with ena=0: reset overrides enable), then free run.
        step(1, 1, 0, 0, 0, 0, 0, 0, 32'h00400000, 0, 0, 0, 0, 0, "reset");
        step(1, 0, 0, 0, 0, 0, 1, 32'h00400800, 32'h00400000, 0, 0, 0, 0, 0, "reset_ena0");
        idle(32'h00400004, 0, "seq1");
        idle(32'h00400008, 0, "seq2");
        idle(32'h0040000C, 0, "seq3");

        // Plain branch redirect and following sequential fetch.
        step(0, 1, 0, 0, 0, 0, 1, 32'h00400100, 32'h00400100, 1, 1, 1, 0, 0, "br");
        idle(32'h00400104, 1, "br_seq");

        // Stall: capture branch, overwrite with exception, lower branch dropped.
        step(0, 1, 1, 0, 0, 0, 1, 32'h00400200, 32'h00400104, 0, 2, 1, 1, 0, "stall_br");
        step(0, 1, 1, 1, 0, 0, 0, 0,            32'h00400104, 0, 3, 1, 1, 0, "stall_exc");
        step(0, 1, 1, 0, 0, 0, 1, 32'h00400300, 32'h00400104, 0, 3, 0, 1, 0, "stall_br_drop");
        idle(32'h00400004, 3, "apply_pending");
        idle(32'h00400008, 3, "after_pending");

        // All three at once: exception wins, epoch 3 wraps to 0.
        step(0, 1, 0, 1, 1, 32'h00401000, 1, 32'h00400300, 32'h00400004, 1, 0, 1, 0, 0, "simul");

        // Misaligned target is masked and flagged.
        step(0, 1, 0, 0, 0, 0, 1, 32'h00400102, 32'h00400100, 1, 1, 1, 0, 1, "misalign");
        idle(32'h00400104, 1, "misalign_seq");

        // PC wrap at top of address space.
        step(0, 1, 0, 0, 0, 0, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 1, 2, 1, 0, 0, "br_top");
        idle(32'h00000000, 2, "wrap");

        // Disabled: state frozen, branch request ignored.
        for (int i = 0; i < 4; i++)
            step(0, 0, 0, 0, 0, 0, 1, 32'h00400500, 32'h00000000, 1, 2, 0, 0, 0, "ena0");
        idle(32'h00000004, 2, "ena_resume");

        // Reset while stalled with a full slot: slot must be discarded.
        step(0, 1, 1, 0, 1, 32'h00402000, 0, 0, 32'h00000004, 0, 3, 1, 1, 0, "stall_eret");
        step(1, 1, 1, 0, 0, 0, 0, 0,            32'h00400000, 0, 0, 0, 0, 0, "rst_pending");
        idle(32'h00400004, 0, "post_rst");

        // Pending branch outranked by new ERET on release.
        step(0, 1, 1, 0, 0, 0, 1, 32'h00400600, 32'h00400004, 0, 1, 1, 1, 0, "stall_br2");
        step(0, 1, 0, 0, 1, 32'h00400700, 0, 0, 32'h00400700, 1, 2, 1, 0, 0, "eret_outranks");
        // Pending exception not outranked by new branch on release.
        step(0, 1, 1, 1, 0, 0, 0, 0,            32'h00400700, 0, 3, 1, 1, 0, "stall_exc2");
        step(0, 1, 0, 0, 0, 0, 1, 32'h00400800, 32'h00400004, 1, 3, 0, 0, 0, "br_lower_drop");
        idle(32'h00400008, 3, "final_seq");

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d entries left want 0", exp_q.size());
        end
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule
